alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a single shared, registered ALU.
// A request sampled in IDLE is captured and issued to the ALU for one cycle
// (ISSUE), then the arbiter waits for ALU_OUT_VALID (WAIT) and returns the
// result tagged with the winning requester's index.
// Optional feature: define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration
// between simultaneous requests; otherwise requester 0 always wins ties.
module alu_arbiter #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 2 * IN_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ0,
  input  logic                 REQ1,
  input  logic [IN_WIDTH-1:0]  A0,
  input  logic [IN_WIDTH-1:0]  B0,
  input  logic [IN_WIDTH-1:0]  A1,
  input  logic [IN_WIDTH-1:0]  B1,
  input  logic [3:0]           FUN0,
  input  logic [3:0]           FUN1,
  output logic                 GNT0,
  output logic                 GNT1,
  output logic [IN_WIDTH-1:0]  ALU_A,
  output logic [IN_WIDTH-1:0]  ALU_B,
  output logic [3:0]           ALU_FUN,
  output logic                 ALU_EN,
  input  logic [OUT_WIDTH-1:0] ALU_OUT,
  input  logic                 ALU_OUT_VALID,
  output logic [OUT_WIDTH-1:0] RSP_DATA,
  output logic                 RSP_VALID,
  output logic                 RSP_ID,
  output logic                 BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e                 state_q;
  logic                   win_q;
  logic                   gnt0_q;
  logic                   gnt1_q;
  logic                   alu_en_q;
  logic [IN_WIDTH-1:0]    alu_a_q;
  logic [IN_WIDTH-1:0]    alu_b_q;
  logic [3:0]             alu_fun_q;
  logic [OUT_WIDTH-1:0]   rsp_data_q;
  logic                   rsp_valid_q;
  logic                   rsp_id_q;
  logic                   busy_q;

  logic                   win_d;
  logic [IN_WIDTH-1:0]    cap_a_d;
  logic [IN_WIDTH-1:0]    cap_b_d;
  logic [3:0]             cap_fun_d;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // prio_q names the requester that wins the next tie (0 after reset).
  logic                   prio_q;

  // Winner selection: on a tie the favoured requester wins.
  always_comb begin
    win_d = 1'b0;
    if (REQ0 && REQ1) begin
      win_d = prio_q;
    end else if (REQ0) begin
      win_d = 1'b0;
    end else begin
      win_d = 1'b1;
    end
  end
`else
  // Winner selection: requester 0 always wins a tie.
  always_comb begin
    win_d = 1'b0;
    if (REQ0) begin
      win_d = 1'b0;
    end else begin
      win_d = 1'b1;
    end
  end
`endif

  // Operand mux: select the winner's operands for capture.
  always_comb begin
    cap_a_d   = A0;
    cap_b_d   = B0;
    cap_fun_d = FUN0;
    if (win_d) begin
      cap_a_d   = A1;
      cap_b_d   = B1;
      cap_fun_d = FUN1;
    end else begin
      cap_a_d   = A0;
      cap_b_d   = B0;
      cap_fun_d = FUN0;
    end
  end

  // Arbiter FSM with all outputs registered; ALU drive is zero outside ISSUE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      win_q       <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      alu_en_q    <= 1'b0;
      alu_a_q     <= {IN_WIDTH{1'b0}};
      alu_b_q     <= {IN_WIDTH{1'b0}};
      alu_fun_q   <= 4'd0;
      rsp_data_q  <= {OUT_WIDTH{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      prio_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A response pulse from the previous op never blocks a new capture.
          rsp_valid_q <= 1'b0;
          if (REQ0 || REQ1) begin
            state_q   <= ST_ISSUE;
            win_q     <= win_d;
            gnt0_q    <= ~win_d;
            gnt1_q    <= win_d;
            alu_en_q  <= 1'b1;
            alu_a_q   <= cap_a_d;
            alu_b_q   <= cap_b_d;
            alu_fun_q <= cap_fun_d;
            busy_q    <= 1'b1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            prio_q    <= ~win_d;
`endif
          end else begin
            state_q   <= ST_IDLE;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            alu_en_q  <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        ST_ISSUE: begin
          state_q     <= ST_WAIT;
          gnt0_q      <= 1'b0;
          gnt1_q      <= 1'b0;
          alu_en_q    <= 1'b0;
          alu_a_q     <= {IN_WIDTH{1'b0}};
          alu_b_q     <= {IN_WIDTH{1'b0}};
          alu_fun_q   <= 4'd0;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b1;
        end
        ST_WAIT: begin
          // No timeout: a stalled ALU keeps the arbiter here indefinitely.
          if (ALU_OUT_VALID) begin
            state_q     <= ST_IDLE;
            rsp_data_q  <= ALU_OUT;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= win_q;
            busy_q      <= 1'b0;
          end else begin
            state_q     <= ST_WAIT;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          gnt0_q      <= 1'b0;
          gnt1_q      <= 1'b0;
          alu_en_q    <= 1'b0;
          alu_a_q     <= {IN_WIDTH{1'b0}};
          alu_b_q     <= {IN_WIDTH{1'b0}};
          alu_fun_q   <= 4'd0;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign GNT0      = gnt0_q;
  assign GNT1      = gnt1_q;
  assign ALU_EN    = alu_en_q;
  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_FUN   = alu_fun_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_ID    = rsp_id_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small registered ALU model.
module tb_alu_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ0, REQ1;
  logic [7:0]  A0, B0, A1, B1;
  logic [3:0]  FUN0, FUN1;
  logic        GNT0, GNT1;
  logic [7:0]  ALU_A, ALU_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VALID;
  logic [15:0] RSP_DATA;
  logic        RSP_VALID, RSP_ID, BUSY;

  logic        auto_alu;
  logic        man_valid;
  logic [15:0] man_out;
  logic        model_valid;
  logic [15:0] model_out;
  logic        exp_id;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  alu_arbiter #(.IN_WIDTH(8), .OUT_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .REQ1(REQ1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .FUN0(FUN0), .FUN1(FUN1),
    .GNT0(GNT0), .GNT1(GNT1),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
    .RSP_DATA(RSP_DATA), .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .BUSY(BUSY)
  );

  // Registered ALU model: add, sub, mul; other codes yield 0.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      model_valid <= 1'b0;
      model_out   <= 16'd0;
    end else begin
      model_valid <= ALU_EN;
      case (ALU_FUN)
        4'b0000: model_out <= {8'd0, ALU_A} + {8'd0, ALU_B};
        4'b0001: model_out <= {8'd0, ALU_A} - {8'd0, ALU_B};
        4'b0010: model_out <= {8'd0, ALU_A} * {8'd0, ALU_B};
        default: model_out <= 16'd0;
      endcase
    end
  end

  assign ALU_OUT_VALID = auto_alu ? model_valid : man_valid;
  assign ALU_OUT       = auto_alu ? model_out   : man_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0;
    A0 = 8'd0; B0 = 8'd0; A1 = 8'd0; B1 = 8'd0; FUN0 = 4'd0; FUN1 = 4'd0;
    auto_alu = 1'b1; man_valid = 1'b0; man_out = 16'd0;

    // reset state
    cyc(); cyc();
    chk("rst_gnt0", {31'd0, GNT0}, 32'd0);
    chk("rst_alu_en", {31'd0, ALU_EN}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
    chk("rst_rsp_data", {16'd0, RSP_DATA}, 32'd0);
    RST = 1'b1;
    cyc();
    chk("idle_busy", {31'd0, BUSY}, 32'd0);

    // single op: 200 + 100
    REQ0 = 1'b1; A0 = 8'd200; B0 = 8'd100; FUN0 = 4'b0000;
    cyc();
    chk("single_gnt0", {31'd0, GNT0}, 32'd1);
    chk("single_alu_en", {31'd0, ALU_EN}, 32'd1);
    chk("single_alu_a", {24'd0, ALU_A}, 32'd200);
    chk("single_alu_b", {24'd0, ALU_B}, 32'd100);
    chk("single_busy", {31'd0, BUSY}, 32'd1);
    REQ0 = 1'b0;
    cyc();
    chk("single_gnt0_off", {31'd0, GNT0}, 32'd0);
    chk("single_alu_en_off", {31'd0, ALU_EN}, 32'd0);
    chk("single_alu_a_zero", {24'd0, ALU_A}, 32'd0);
    chk("single_rsp_early", {31'd0, RSP_VALID}, 32'd0);
    cyc();
    chk("single_rsp_valid", {31'd0, RSP_VALID}, 32'd1);
    chk("single_rsp_data", {16'd0, RSP_DATA}, 32'd300);
    chk("single_rsp_id", {31'd0, RSP_ID}, 32'd0);
    chk("single_busy_off", {31'd0, BUSY}, 32'd0);
    cyc();
    chk("single_rsp_pulse", {31'd0, RSP_VALID}, 32'd0);
    chk("single_rsp_hold", {16'd0, RSP_DATA}, 32'd300);

    // reset to restore the tie pointer, then contention
    RST = 1'b0;
    cyc();
    RST = 1'b1;
    REQ0 = 1'b1; A0 = 8'd15; B0 = 8'd15; FUN0 = 4'b0010;
    REQ1 = 1'b1; A1 = 8'd5;  B1 = 8'd3;  FUN1 = 4'b0001;
    for (int i = 0; i < 6; i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      exp_id = (i % 2 == 1);
`else
      exp_id = 1'b0;
`endif
      cyc();
      chk("cont_gnt0", {31'd0, GNT0}, {31'd0, ~exp_id});
      chk("cont_gnt1", {31'd0, GNT1}, {31'd0, exp_id});
      cyc(); cyc();
      chk("cont_rsp_valid", {31'd0, RSP_VALID}, 32'd1);
      chk("cont_rsp_id", {31'd0, RSP_ID}, {31'd0, exp_id});
      chk("cont_rsp_data", {16'd0, RSP_DATA}, exp_id ? 32'd2 : 32'd225);
    end
    REQ0 = 1'b0;
    cyc();
    chk("cont_tail_gnt1", {31'd0, GNT1}, 32'd1);
    REQ1 = 1'b0;
    cyc(); cyc();
    chk("cont_tail_rsp_data", {16'd0, RSP_DATA}, 32'd2);
    chk("cont_tail_rsp_id", {31'd0, RSP_ID}, 32'd1);

    // late request: REQ1 rises while requester 0's op is in WAIT
    REQ0 = 1'b1; A0 = 8'd1; B0 = 8'd2; FUN0 = 4'b0000;
    cyc();
    chk("late_gnt0", {31'd0, GNT0}, 32'd1);
    REQ0 = 1'b0;
    cyc();
    REQ1 = 1'b1; A1 = 8'd9; B1 = 8'd2; FUN1 = 4'b0001;
    cyc();
    chk("late_rsp_data", {16'd0, RSP_DATA}, 32'd3);
    chk("late_no_gnt1", {31'd0, GNT1}, 32'd0);
    chk("late_idle", {31'd0, BUSY}, 32'd0);
    cyc();
    chk("late_gnt1", {31'd0, GNT1}, 32'd1);
    chk("late_alu_a", {24'd0, ALU_A}, 32'd9);
    chk("late_alu_fun", {28'd0, ALU_FUN}, 32'd1);
    REQ1 = 1'b0;
    cyc(); cyc();
    chk("late_rsp2_data", {16'd0, RSP_DATA}, 32'd7);
    chk("late_rsp2_id", {31'd0, RSP_ID}, 32'd1);

    // reset in WAIT
    REQ0 = 1'b1; A0 = 8'd3; B0 = 8'd4; FUN0 = 4'b0010;
    cyc();
    chk("rmid_gnt0", {31'd0, GNT0}, 32'd1);
    REQ0 = 1'b0;
    cyc();
    #2 RST = 1'b0;
    #1;
    chk("rmid_busy", {31'd0, BUSY}, 32'd0);
    chk("rmid_rsp_data", {16'd0, RSP_DATA}, 32'd0);
    chk("rmid_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
    chk("rmid_alu_en", {31'd0, ALU_EN}, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    chk("rmid_no_rsp", {31'd0, RSP_VALID}, 32'd0);
    auto_alu = 1'b0; man_valid = 1'b1; man_out = 16'h1234;
    cyc();
    chk("rmid_late_valid_ignored", {31'd0, RSP_VALID}, 32'd0);
    chk("rmid_late_data_ignored", {16'd0, RSP_DATA}, 32'd0);
    man_valid = 1'b0; auto_alu = 1'b1;
    REQ0 = 1'b1; A0 = 8'd10; B0 = 8'd20; FUN0 = 4'b0000;
    cyc();
    chk("rmid_next_gnt0", {31'd0, GNT0}, 32'd1);
    REQ0 = 1'b0;
    cyc(); cyc();
    chk("rmid_next_rsp_valid", {31'd0, RSP_VALID}, 32'd1);
    chk("rmid_next_rsp_data", {16'd0, RSP_DATA}, 32'd30);

    // stalled ALU, undefined FUN code 1111 passes through
    auto_alu = 1'b0; man_valid = 1'b0;
    REQ0 = 1'b1; A0 = 8'h11; B0 = 8'h22; FUN0 = 4'b1111;
    cyc();
    chk("stall_gnt0", {31'd0, GNT0}, 32'd1);
    chk("stall_alu_fun", {28'd0, ALU_FUN}, 32'hF);
    chk("stall_alu_b", {24'd0, ALU_B}, 32'h22);
    REQ0 = 1'b0;
    REQ1 = 1'b1; A1 = 8'd1; B1 = 8'd1; FUN1 = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("stall_busy", {31'd0, BUSY}, 32'd1);
      chk("stall_no_gnt", {31'd0, GNT0 | GNT1}, 32'd0);
    end
    man_out = 16'h00AB; man_valid = 1'b1;
    cyc();
    chk("stall_rsp_valid", {31'd0, RSP_VALID}, 32'd1);
    chk("stall_rsp_data", {16'd0, RSP_DATA}, 32'h00AB);
    chk("stall_rsp_id", {31'd0, RSP_ID}, 32'd0);
    man_valid = 1'b0; auto_alu = 1'b1;
    cyc();
    chk("stall_then_gnt1", {31'd0, GNT1}, 32'd1);
    REQ1 = 1'b0;
    cyc(); cyc();
    chk("stall_rsp2_data", {16'd0, RSP_DATA}, 32'd2);
    chk("stall_rsp2_id", {31'd0, RSP_ID}, 32'd1);
    cyc();
    chk("stall_rsp2_pulse", {31'd0, RSP_VALID}, 32'd0);
    chk("stall_rsp2_hold", {16'd0, RSP_DATA}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
